// File: rtl/seed_window_feeder.sv
// Sliding K-base window feeder for the pipelined seed comparator.
// Optional HIT_COUNT_EN adds a saturating hit_count output.
module seed_window_feeder #(
  parameter int K          = 11,
  parameter int POS_W      = 32,
  parameter int SCORE_W    = 6,
  parameter int HIT_THRESH = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*K-1:0]     query_in,
  input  logic [POS_W-1:0]   seq_len,
  input  logic               base_valid,
  input  logic [1:0]         base_data,
  output logic               base_ready,
  output logic [2*K-1:0]     cmp_query,
  output logic [2*K-1:0]     cmp_db,
  input  logic [SCORE_W-1:0] cmp_score,
  output logic               hit_valid,
  output logic [POS_W-1:0]   hit_pos,
  output logic [SCORE_W-1:0] hit_score,
`ifdef HIT_COUNT_EN
  output logic [POS_W-1:0]   hit_count,
`endif
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [POS_W-1:0] K_P = POS_W'(K);
  localparam logic [SCORE_W-1:0] TH_P = SCORE_W'(HIT_THRESH);

  logic [1:0]         state_q, state_d;
  logic [2*K-1:0]     query_q, query_d;
  logic [2*K-1:0]     db_q, db_d;
  logic [POS_W-1:0]   len_q, len_d;
  logic [POS_W-1:0]   cnt_q, cnt_d;
  logic               win_v_q, win_v_d;
  logic [POS_W-1:0]   win_pos_q, win_pos_d;
  logic               sc_v_q, sc_v_d;
  logic [POS_W-1:0]   sc_pos_q, sc_pos_d;
  logic               hit_v_q, hit_v_d;
  logic [POS_W-1:0]   hit_pos_q, hit_pos_d;
  logic [SCORE_W-1:0] hit_sc_q, hit_sc_d;
  logic               fl_q, fl_d;
  logic [POS_W-1:0]   cnt_inc;
  logic               xfer;

  assign base_ready = (state_q == S_RUN);
  assign xfer       = base_ready & base_valid;
  assign cnt_inc    = cnt_q + POS_W'(1);

  always_comb begin
    state_d   = state_q;
    query_d   = query_q;
    db_d      = db_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    win_v_d   = 1'b0;
    win_pos_d = win_pos_q;
    fl_d      = fl_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          query_d = query_in;
          len_d   = seq_len;
          cnt_d   = '0;
          db_d    = '0;
          fl_d    = 1'b0;
          state_d = (seq_len == '0) ? S_FLUSH : S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          db_d      = {db_q[2*K-3:0], base_data};
          cnt_d     = cnt_inc;
          win_v_d   = (cnt_inc >= K_P);
          win_pos_d = cnt_inc - K_P;
          if (cnt_inc == len_q) begin
            state_d = S_FLUSH;
            fl_d    = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        // two cycles lets the final window's score reach hit_valid
        fl_d = 1'b1;
        if (fl_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sc_v_d    = win_v_q;
    sc_pos_d  = win_pos_q;
    hit_v_d   = sc_v_q & (cmp_score >= TH_P);
    hit_pos_d = hit_pos_q;
    hit_sc_d  = hit_sc_q;
    if (hit_v_d) begin
      hit_pos_d = sc_pos_q;
      hit_sc_d  = cmp_score;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      query_q   <= '0;
      db_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      win_v_q   <= 1'b0;
      win_pos_q <= '0;
      sc_v_q    <= 1'b0;
      sc_pos_q  <= '0;
      hit_v_q   <= 1'b0;
      hit_pos_q <= '0;
      hit_sc_q  <= '0;
      fl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      query_q   <= query_d;
      db_q      <= db_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      win_v_q   <= win_v_d;
      win_pos_q <= win_pos_d;
      sc_v_q    <= sc_v_d;
      sc_pos_q  <= sc_pos_d;
      hit_v_q   <= hit_v_d;
      hit_pos_q <= hit_pos_d;
      hit_sc_q  <= hit_sc_d;
      fl_q      <= fl_d;
    end
  end

`ifdef HIT_COUNT_EN
  logic [POS_W-1:0] hc_q, hc_d;

  always_comb begin
    hc_d = hc_q;
    if (state_q == S_IDLE && start) hc_d = '0;
    else if (hit_v_q && hc_q != '1) hc_d = hc_q + POS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) hc_q <= '0;
    else     hc_q <= hc_d;
  end

  assign hit_count = hc_q;
`endif

  assign cmp_query = query_q;
  assign cmp_db    = db_q;
  assign hit_valid = hit_v_q;
  assign hit_pos   = hit_pos_q;
  assign hit_score = hit_sc_q;
  assign busy      = (state_q == S_RUN) | (state_q == S_FLUSH);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_seed_window_feeder.sv
// Directed bench for seed_window_feeder with a behavioural
// registered comparator (+5 match, -4 mismatch, floor 0).
module tb_seed_window_feeder;

  localparam int K = 11;
  localparam int PW = 32;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2*K-1:0] query_in = '0;
  logic [PW-1:0] seq_len = '0;
  logic          base_valid = 1'b0;
  logic [1:0]    base_data = '0;
  logic          base_ready;
  logic [2*K-1:0] cmp_query, cmp_db;
  logic [SW-1:0] cmp_score = '0;
  logic          hit_valid;
  logic [PW-1:0] hit_pos;
  logic [SW-1:0] hit_score;
  logic          busy, done;
`ifdef HIT_COUNT_EN
  logic [PW-1:0] hit_count;
`endif

  int checks = 0;
  int failures = 0;
  int done_n = 0;
  int xfer_n = 0;
  logic [PW-1:0] hq_pos[$];
  logic [SW-1:0] hq_sc[$];

  seed_window_feeder dut (
    .clk(clk), .rst(rst), .start(start),
    .query_in(query_in), .seq_len(seq_len),
    .base_valid(base_valid), .base_data(base_data),
    .base_ready(base_ready),
    .cmp_query(cmp_query), .cmp_db(cmp_db),
    .cmp_score(cmp_score),
    .hit_valid(hit_valid), .hit_pos(hit_pos),
    .hit_score(hit_score),
`ifdef HIT_COUNT_EN
    .hit_count(hit_count),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] score_f(
    input logic [2*K-1:0] q, input logic [2*K-1:0] d);
    int s;
    s = 0;
    for (int i = 0; i < K; i++)
      s += (q[2*i+:2] == d[2*i+:2]) ? 5 : -4;
    if (s < 0) s = 0;
    return s[SW-1:0];
  endfunction

  always @(posedge clk) begin
    cmp_score <= score_f(cmp_query, cmp_db);
    if (base_valid && base_ready) xfer_n <= xfer_n + 1;
  end

  always @(negedge clk) begin
    if (hit_valid) begin
      hq_pos.push_back(hit_pos);
      hq_sc.push_back(hit_score);
    end
    if (done) done_n++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hq_pos.delete();
    hq_sc.delete();
    done_n = 0;
    xfer_n = 0;
  endtask

  task automatic go(input logic [2*K-1:0] q,
                    input logic [PW-1:0] n);
    @(negedge clk);
    start = 1'b1;
    query_in = q;
    seq_len = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] b, input int gap);
    int w;
    repeat (gap) begin
      @(negedge clk);
      base_valid = 1'b0;
    end
    @(negedge clk);
    base_valid = 1'b1;
    base_data = b;
    w = 0;
    while (!base_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int w;
    @(negedge clk);
    base_valid = 1'b0;
    w = 0;
    while (!done && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", base_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_hitv", hit_valid, 0);
    chk("rst_hitpos", hit_pos, 0);
    chk("rst_db", cmp_db, 0);
    rst = 1'b0;

    // one full window of base 0
    clr();
    go(22'h0, 11);
    chk("c1_busy", busy, 1);
    for (int i = 0; i < 11; i++) send(2'd0, 0);
    wait_done();
    chk("c1_nhits", hq_pos.size(), 1);
    if (hq_pos.size() == 1) begin
      chk("c1_pos", hq_pos[0], 0);
      chk("c1_score", hq_sc[0], 55);
    end
    chk("c1_done", done_n, 1);
    chk("c1_idle", busy, 0);
`ifdef HIT_COUNT_EN
    chk("c1_hcount", hit_count, 1);
`endif

    // two windows
    clr();
    go(22'h0, 12);
    for (int i = 0; i < 11; i++) send(2'd0, 0);
    send(2'd1, 0);
    wait_done();
    chk("c2_nhits", hq_pos.size(), 2);
    if (hq_pos.size() == 2) begin
      chk("c2_pos0", hq_pos[0], 0);
      chk("c2_sc0", hq_sc[0], 55);
      chk("c2_pos1", hq_pos[1], 1);
      chk("c2_sc1", hq_sc[1], 46);
    end
    chk("c2_done", done_n, 1);
    chk("c2_hold", hit_pos, 1);

    // all mismatches
    clr();
    go(22'h0, 20);
    for (int i = 0; i < 20; i++) send(2'd1, 0);
    wait_done();
    chk("c3_nhits", hq_pos.size(), 0);
    chk("c3_done", done_n, 1);
    chk("c3_xfer", xfer_n, 20);

    // short sequence, extra base offered
    clr();
    go(22'h0, 5);
    for (int i = 0; i < 5; i++) send(2'd0, 0);
    @(negedge clk);
    chk("c4_ready", base_ready, 0);
    repeat (6) @(negedge clk);
    chk("c4_xfer", xfer_n, 5);
    base_valid = 1'b0;
    chk("c4_nhits", hq_pos.size(), 0);
    chk("c4_done", done_n, 1);

    // zero length
    clr();
    go(22'h0, 0);
    chk("c0_ready", base_ready, 0);
    wait_done();
    chk("c0_done", done_n, 1);
    chk("c0_xfer", xfer_n, 0);

    // valid toggling
    clr();
    go(22'h0, 12);
    for (int i = 0; i < 11; i++) send(2'd0, 1);
    send(2'd1, 1);
    wait_done();
    chk("c5_nhits", hq_pos.size(), 2);
    if (hq_pos.size() == 2) begin
      chk("c5_pos0", hq_pos[0], 0);
      chk("c5_sc0", hq_sc[0], 55);
      chk("c5_pos1", hq_pos[1], 1);
      chk("c5_sc1", hq_sc[1], 46);
    end
    chk("c5_xfer", xfer_n, 12);

    // reset mid-run
    clr();
    go(22'h3, 20);
    for (int i = 0; i < 5; i++) send(2'd2, 0);
    @(negedge clk);
    base_valid = 1'b0;
    chk("c6_pre_q", cmp_query, 22'h3);
    rst = 1'b1;
    @(negedge clk);
    chk("c6_busy", busy, 0);
    chk("c6_ready", base_ready, 0);
    chk("c6_q", cmp_query, 0);
    chk("c6_db", cmp_db, 0);
    chk("c6_hitpos", hit_pos, 0);
    chk("c6_hitsc", hit_score, 0);
    chk("c6_hitv", hit_valid, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("c6_nodone", done_n, 0);

    clr();
    go(22'h0, 11);
    for (int i = 0; i < 11; i++) send(2'd0, 0);
    wait_done();
    chk("c7_nhits", hq_pos.size(), 1);
    if (hq_pos.size() == 1) chk("c7_sc", hq_sc[0], 55);
    chk("c7_done", done_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
